pb_intr_ctrl: RTL and testbench

Parametrised push-button interrupt controller for the digital-clock SoC. It synchronises and debounces N active-low buttons and latches press and optional release events into a sticky, write-1-to-clear pending register with a per-channel mask. It drives a single active-low interrupt line to the CPU and sits on the same simple register bus as the other clock peripherals.

---
 rtl/pb_intr_ctrl.sv | 153 +++++++++++++++
 tb/tb_pb_intr_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pb_intr_ctrl.sv
// Push-button interrupt controller: sync + debounce per channel, W1C pending, mask, active-low INTR.
// Optional auto-repeat on held buttons when PB_REPEAT_EN is defined.
module pb_intr_ctrl #(
    parameter int N_PB         = 3,
    parameter int DEBOUNCE_CYC = 16,
    parameter int CNT_W        = 20,
    parameter int HOLD_CYC     = 1000,
    parameter int REPEAT_CYC   = 250
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic [N_PB-1:0] PB,
    input  logic [1:0]      addr,
    input  logic            wr_en,
    input  logic [31:0]     wr_data,
    output logic [31:0]     rd_data,
    output logic            INTR
);

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic [N_PB-1:0]  sync1;
    logic [N_PB-1:0]  sync2;
    logic [N_PB-1:0]  sync_lvl;
    logic [N_PB-1:0]  stable;
    logic [N_PB-1:0]  toggle;
    logic [N_PB-1:0]  rise;
    logic [N_PB-1:0]  fall;
    logic [N_PB-1:0]  rep_ev;
    logic [N_PB-1:0]  set_ev;
    logic [N_PB-1:0]  clr;
    logic [N_PB-1:0]  pending;
    logic [N_PB-1:0]  mask_q;
    logic [N_PB-1:0]  edge_q;
    logic [CNT_W-1:0] cnt [N_PB];
    logic             unused_wr_bits;

    assign unused_wr_bits = ^wr_data[31:N_PB];

    // Synchroniser idles at 1 so reset release never looks like a press.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= PB;
            sync2 <= sync1;
        end
    end

    assign sync_lvl = ~sync2;

    always_comb begin
        toggle = '0;
        for (int i = 0; i < N_PB; i++) begin
            toggle[i] = (sync_lvl[i] != stable[i]) && (cnt[i] == DB_LAST);
        end
    end

    assign rise = toggle & ~stable;
    assign fall = toggle & stable;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stable <= '0;
            for (int i = 0; i < N_PB; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            stable <= stable ^ toggle;
            for (int i = 0; i < N_PB; i++) begin
                if (sync_lvl[i] == stable[i] || cnt[i] == DB_LAST) begin
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

`ifdef PB_REPEAT_EN
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYC - 1);

    logic [CNT_W-1:0] hold_cnt [N_PB];
    logic [N_PB-1:0]  rep_phase;

    // First repeat uses the long hold interval, later ones the short interval.
    always_comb begin
        rep_ev = '0;
        for (int i = 0; i < N_PB; i++) begin
            rep_ev[i] = stable[i] && !toggle[i] &&
                        (rep_phase[i] ? (hold_cnt[i] == REP_LAST) : (hold_cnt[i] == HOLD_LAST));
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rep_phase <= '0;
            for (int i = 0; i < N_PB; i++) begin
                hold_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_PB; i++) begin
                if (toggle[i] || !stable[i]) begin
                    hold_cnt[i]  <= '0;
                    rep_phase[i] <= 1'b0;
                end else if (rep_ev[i]) begin
                    hold_cnt[i]  <= '0;
                    rep_phase[i] <= 1'b1;
                end else begin
                    hold_cnt[i] <= hold_cnt[i] + 1'b1;
                end
            end
        end
    end
`else
    assign rep_ev = '0;
`endif

    assign set_ev = rise | (fall & edge_q) | rep_ev;
    assign clr    = (wr_en && addr == 2'd1) ? wr_data[N_PB-1:0] : '0;

    // A set in the same cycle as a W1C of that bit wins.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pending <= '0;
            mask_q  <= '1;
            edge_q  <= '0;
            INTR    <= 1'b1;
        end else begin
            pending <= (pending & ~clr) | set_ev;
            if (wr_en && addr == 2'd2) begin
                mask_q <= wr_data[N_PB-1:0];
            end
            if (wr_en && addr == 2'd3) begin
                edge_q <= wr_data[N_PB-1:0];
            end
            INTR <= ~|(pending & mask_q);
        end
    end

    always_comb begin
        rd_data = '0;
        case (addr)
            2'd0:    rd_data = 32'(stable);
            2'd1:    rd_data = 32'(pending);
            2'd2:    rd_data = 32'(mask_q);
            default: rd_data = 32'(edge_q);
        endcase
    end

endmodule

// File: tb/tb_pb_intr_ctrl.sv
// Self-checking bench for pb_intr_ctrl: directed scenarios plus random button/bus traffic
// checked against a time-based reference model. Honours PB_REPEAT_EN like the design.
module tb_pb_intr_ctrl;

    localparam int N    = 3;
    localparam int DB   = 16;
    localparam int HOLD = 100;
    localparam int REP  = 50;

    logic        clk;
    logic        resetn;
    logic [N-1:0] PB;
    logic [1:0]  addr;
    logic        wr_en;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        INTR;

    int checks;
    int errors;

    pb_intr_ctrl #(
        .N_PB(N), .DEBOUNCE_CYC(DB), .CNT_W(20), .HOLD_CYC(HOLD), .REPEAT_CYC(REP)
    ) dut (
        .clk(clk), .resetn(resetn), .PB(PB), .addr(addr), .wr_en(wr_en),
        .wr_data(wr_data), .rd_data(rd_data), .INTR(INTR)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: raw-input delay line, and per channel the edge at which the
    // synchronised level started disagreeing with the accepted level.
    int           edge_n;
    logic [N-1:0] pb_d1, pb_d2;
    logic [N-1:0] m_stable, m_pending, m_mask, m_edge;
    logic         m_intr;
    int           dis_start [N];
    int           press_edge [N];

    task automatic model_reset();
        edge_n = 0;
        pb_d1 = '1; pb_d2 = '1;
        m_stable = '0; m_pending = '0; m_mask = '1; m_edge = '0; m_intr = 1'b1;
        for (int i = 0; i < N; i++) begin
            dis_start[i]  = -1;
            press_edge[i] = 0;
        end
    endtask

    task automatic model_edge();
        logic [N-1:0] sync_now, tog, setv, clrv;
        logic         intr_next;
        sync_now  = ~pb_d2;
        intr_next = ~|(m_pending & m_mask);
        tog = '0; setv = '0;
        for (int i = 0; i < N; i++) begin
            if (sync_now[i] == m_stable[i]) begin
                dis_start[i] = -1;
            end else begin
                if (dis_start[i] < 0) dis_start[i] = edge_n;
                if (edge_n - dis_start[i] + 1 >= DB) begin
                    tog[i] = 1'b1;
                    dis_start[i] = -1;
                end
            end
`ifdef PB_REPEAT_EN
            if (m_stable[i] && !tog[i] && (edge_n - press_edge[i]) >= HOLD &&
                ((edge_n - press_edge[i] - HOLD) % REP) == 0)
                setv[i] = 1'b1;
`endif
            if (tog[i] && !m_stable[i]) begin
                setv[i] = 1'b1;
                press_edge[i] = edge_n;
            end else if (tog[i] && m_edge[i]) begin
                setv[i] = 1'b1;
            end
        end
        clrv = (wr_en && addr == 2'd1) ? wr_data[N-1:0] : '0;
        m_pending = (m_pending & ~clrv) | setv;
        if (wr_en && addr == 2'd2) m_mask = wr_data[N-1:0];
        if (wr_en && addr == 2'd3) m_edge = wr_data[N-1:0];
        m_stable = m_stable ^ tog;
        m_intr   = intr_next;
        pb_d2 = pb_d1;
        pb_d1 = PB;
        edge_n++;
    endtask

    function automatic logic [31:0] model_rd(input logic [1:0] a);
        case (a)
            2'd0:    return 32'(m_stable);
            2'd1:    return 32'(m_pending);
            2'd2:    return 32'(m_mask);
            default: return 32'(m_edge);
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, edge_n);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("intr_model", 32'(INTR), 32'(m_intr));
        chk("rd_model", rd_data, model_rd(addr));
        wr_en = 1'b0;
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic write(input logic [1:0] a, input logic [31:0] d);
        addr = a; wr_data = d; wr_en = 1'b1;
        step();
    endtask

    task automatic read_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        chk(tag, rd_data, exp);
        chk({tag, "_model"}, rd_data, model_rd(a));
    endtask

    int ev_edges [$];

    initial begin
        checks = 0; errors = 0;
        resetn = 1'b0; PB = '1; addr = 2'd0; wr_en = 1'b0; wr_data = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_intr", 32'(INTR), 32'h1);
        read_chk("reset_mask", 2'd2, 32'h7);
        read_chk("reset_edge", 2'd3, 32'h0);
        @(negedge clk);
        resetn = 1'b1;

        steps(100);
        chk("idle_intr", 32'(INTR), 32'h1);
        read_chk("idle_status", 2'd0, 32'h0);
        read_chk("idle_pending", 2'd1, 32'h0);
        read_chk("idle_mask", 2'd2, 32'h7);

        // Press PB[1]: pending at E17, INTR low at E18.
        addr = 2'd1;
        PB = 3'b101;
        steps(17);
        chk("press_pending_pre", rd_data, 32'h0);
        step();
        chk("press_pending_e17", rd_data, 32'h2);
        chk("press_intr_e17", 32'(INTR), 32'h1);
        step();
        chk("press_intr_e18", 32'(INTR), 32'h0);
        write(2'd1, 32'h2);
        chk("w1c_intr_w", 32'(INTR), 32'h0);
        step();
        chk("w1c_intr_w1", 32'(INTR), 32'h1);
        PB = 3'b111;
        steps(25);
        read_chk("release_noedge", 2'd1, 32'h0);

        // Bounce shorter than the debounce window.
        for (int k = 0; k < 20; k++) begin
            PB[0] = k[0];
            steps(5);
            chk("bounce_status", model_rd(2'd0), 32'h0);
        end
        PB = 3'b111;
        steps(30);
        chk("bounce_intr", 32'(INTR), 32'h1);
        read_chk("bounce_status_end", 2'd0, 32'h0);
        read_chk("bounce_pending_end", 2'd1, 32'h0);

        // Masked channel still latches; unmasking raises INTR next cycle.
        write(2'd2, 32'h6);
        PB = 3'b110;
        steps(22);
        chk("mask_intr_high", 32'(INTR), 32'h1);
        read_chk("mask_pending", 2'd1, 32'h1);
        write(2'd2, 32'h7);
        chk("unmask_intr_w", 32'(INTR), 32'h1);
        step();
        chk("unmask_intr_w1", 32'(INTR), 32'h0);
        write(2'd1, 32'h1);
        PB = 3'b111;
        steps(25);

        // Release events only with EDGE set.
        write(2'd3, 32'h4);
        PB = 3'b011;
        steps(22);
        read_chk("edge_press", 2'd1, 32'h4);
        write(2'd1, 32'h4);
        PB = 3'b111;
        steps(22);
        read_chk("edge_release", 2'd1, 32'h4);
        write(2'd1, 32'h4);
        write(2'd3, 32'h0);
        PB = 3'b011;
        steps(22);
        read_chk("noedge_press", 2'd1, 32'h4);
        write(2'd1, 32'h4);
        PB = 3'b111;
        steps(22);
        read_chk("noedge_release", 2'd1, 32'h0);

        // Press event on the same edge as a W1C of that bit: set wins.
        PB = 3'b011;
        steps(17);
        write(2'd1, 32'h4);
        chk("set_beats_clr", rd_data, 32'h4);
        write(2'd1, 32'h4);
        PB = 3'b111;
        steps(25);

        // Long hold: one event, or auto-repeat when enabled.
        begin
            int t0;
            t0 = edge_n;
            addr = 2'd1;
            PB = 3'b110;
            for (int k = 0; k < 300; k++) begin
                if (rd_data[0]) begin
                    ev_edges.push_back(edge_n - t0);
                    write(2'd1, 32'h1);
                end else begin
                    addr = 2'd1;
                    step();
                end
            end
            PB = 3'b111;
            steps(40);
            write(2'd1, 32'h7);
`ifdef PB_REPEAT_EN
            chk("hold_events", 32'(ev_edges.size()), 32'd5);
            if (ev_edges.size() == 5) begin
                chk("hold_first", 32'(ev_edges[0]), 32'd18);
                for (int j = 1; j < 5; j++)
                    chk("hold_spacing", 32'(ev_edges[j] - ev_edges[0]), 32'(HOLD + (j - 1) * REP));
            end
`else
            chk("hold_events", 32'(ev_edges.size()), 32'd1);
            if (ev_edges.size() == 1) chk("hold_first", 32'(ev_edges[0]), 32'd18);
`endif
        end

        // Random buttons and bus traffic against the model.
        for (int it = 0; it < 80; it++) begin
            int len;
            PB  = 3'($urandom_range(0, 7));
            len = int'($urandom_range(1, 40));
            for (int k = 0; k < len; k++) begin
                addr = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 7) == 0) begin
                    wr_data = $urandom();
                    if (addr == 2'd2 && $urandom_range(0, 1) == 1) wr_data[2:0] = 3'b111;
                    wr_en = 1'b1;
                end
                step();
            end
        end
        PB = 3'b111;
        steps(30);
        for (int a = 0; a < 4; a++) begin
            addr = 2'(a);
            #1;
            chk("final_rd", rd_data, model_rd(2'(a)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
